// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Purpose : 640x480@60 VGA timing constants, counter widths and the shared
//           types used by the vertical counter and the sync decoder.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package vga_timing_pkg;

  // Horizontal timing in pixel clocks.
  localparam int unsigned VGA_H_TOTAL      = 800;
  localparam int unsigned VGA_H_VISIBLE    = 640;
  localparam int unsigned VGA_H_SYNC_START = 656;
  localparam int unsigned VGA_H_SYNC_END   = 752;

  // Vertical timing in lines.
  localparam int unsigned VGA_V_TOTAL      = 525;
  localparam int unsigned VGA_V_VISIBLE    = 480;
  localparam int unsigned VGA_V_SYNC_START = 490;
  localparam int unsigned VGA_V_SYNC_END   = 492;

  // Widths.
  localparam int unsigned H_CNT_W     = 16;
  localparam int unsigned V_CNT_W     = 16;
  localparam int unsigned PIX_W       = 10;
  localparam int unsigned FRAME_CNT_W = 8;

  typedef logic [H_CNT_W-1:0]     hcount_t;
  typedef logic [V_CNT_W-1:0]     vcount_t;
  typedef logic [PIX_W-1:0]       pix_t;
  typedef logic [FRAME_CNT_W-1:0] frame_cnt_t;

  // Everything the decoder registers in one bundle, so the reset value and the
  // next-state value are each written in a single place.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic video_on;
    pix_t pixel_x;
    pix_t pixel_y;
    logic frame_start;
  } sync_out_t;

  localparam sync_out_t SYNC_OUT_RESET = '{
    hsync:       1'b1,
    vsync:       1'b1,
    video_on:    1'b0,
    pixel_x:     '0,
    pixel_y:     '0,
    frame_start: 1'b0
  };

  // Half-open interval test: lo <= v < hi.
  function automatic logic in_range(input logic [15:0] v,
                                    input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_vert_counter.sv
// -----------------------------------------------------------------------------
// vga_vert_counter
// Purpose : Line counter. Advances once per cycle that enable is high and wraps
//           V_TOTAL-1 -> 0. Also exposes the line number the decoder must use
//           this cycle (post-advance value) and the frame-wrap strobe.
// Ports   : clk       - pixel clock
//           rst_n     - synchronous active-low reset
//           enable    - line-advance pulse
//           count     - registered current line
//           line_eff  - combinational effective line (count after this edge)
//           wrap      - combinational: this edge wraps to line 0
// -----------------------------------------------------------------------------
module vga_vert_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned V_TOTAL = VGA_V_TOTAL
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    enable,
  output vcount_t count,
  output vcount_t line_eff,
  output logic    wrap
);

  localparam vcount_t V_LAST = vcount_t'(V_TOTAL - 1);

  vcount_t count_q;
  vcount_t count_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    wrap    = enable && (count_q == V_LAST);
    count_d = count_q;
    if (enable) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign line_eff = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
// Purpose : Turns the upstream horizontal count plus the line-wrap pulse into
//           registered VGA sync, visible-area and pixel-coordinate outputs.
//           All outputs carry one cycle of latency from the horizontalCount
//           sample and decode the line number as it is after this edge.
// Ports   : clk25MHz        - pixel clock
//           reset_n         - synchronous active-low reset
//           enableVertCount - line-advance pulse (coincident with hcount 0)
//           horizontalCount - upstream horizontal position
//           verticalCount   - current line
//           hsync, vsync    - active-low syncs
//           videoOn         - pixel inside the visible area
//           pixelX, pixelY  - visible coordinates, 0 outside the visible area
//           frameStart      - one-cycle pulse on the first pixel of a frame
//           frameCount      - frames seen, wraps 255 -> 0
//                             (only when VGA_FRAME_COUNT_EN is defined)
// Config  : `define VGA_FRAME_COUNT_EN to add the frameCount port and counter.
// -----------------------------------------------------------------------------
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE    = VGA_H_VISIBLE,
  parameter int unsigned H_SYNC_START = VGA_H_SYNC_START,
  parameter int unsigned H_SYNC_END   = VGA_H_SYNC_END,
  parameter int unsigned V_VISIBLE    = VGA_V_VISIBLE,
  parameter int unsigned V_SYNC_START = VGA_V_SYNC_START,
  parameter int unsigned V_SYNC_END   = VGA_V_SYNC_END,
  parameter int unsigned V_TOTAL      = VGA_V_TOTAL
) (
  input  logic                   clk25MHz,
  input  logic                   reset_n,
  input  logic                   enableVertCount,
  input  logic [H_CNT_W-1:0]     horizontalCount,
  output logic [V_CNT_W-1:0]     verticalCount,
  output logic                   hsync,
  output logic                   vsync,
  output logic                   videoOn,
  output logic [PIX_W-1:0]       pixelX,
  output logic [PIX_W-1:0]       pixelY,
  output logic                   frameStart
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frameCount
`endif
);

  localparam hcount_t H_TOTAL_C      = hcount_t'(VGA_H_TOTAL);
  localparam hcount_t H_VISIBLE_C    = hcount_t'(H_VISIBLE);
  localparam hcount_t H_SYNC_START_C = hcount_t'(H_SYNC_START);
  localparam hcount_t H_SYNC_END_C   = hcount_t'(H_SYNC_END);
  localparam vcount_t V_VISIBLE_C    = vcount_t'(V_VISIBLE);
  localparam vcount_t V_SYNC_START_C = vcount_t'(V_SYNC_START);
  localparam vcount_t V_SYNC_END_C   = vcount_t'(V_SYNC_END);

  vcount_t line_eff;
  logic    frame_wrap;

  vga_vert_counter #(
    .V_TOTAL (V_TOTAL)
  ) u_vert_counter (
    .clk      (clk25MHz),
    .rst_n    (reset_n),
    .enable   (enableVertCount),
    .count    (verticalCount),
    .line_eff (line_eff),
    .wrap     (frame_wrap)
  );

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  sync_out_t out_q;
  sync_out_t out_d;
  logic      h_in_line;
  logic      h_visible;
  logic      v_visible;

  always_comb begin
    // Counts at or beyond the line length are out-of-range upstream values and
    // are forced into blanking with hsync inactive.
    h_in_line = horizontalCount < H_TOTAL_C;
    h_visible = h_in_line && (horizontalCount < H_VISIBLE_C);
    v_visible = line_eff < V_VISIBLE_C;

    out_d             = SYNC_OUT_RESET;
    out_d.hsync       = !(h_in_line &&
                          in_range(horizontalCount, H_SYNC_START_C, H_SYNC_END_C));
    out_d.vsync       = !in_range(line_eff, V_SYNC_START_C, V_SYNC_END_C);
    out_d.video_on    = h_visible && v_visible;
    out_d.frame_start = frame_wrap;
    if (out_d.video_on) begin
      out_d.pixel_x = horizontalCount[PIX_W-1:0];
      out_d.pixel_y = line_eff[PIX_W-1:0];
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (!reset_n) begin
      out_q <= SYNC_OUT_RESET;
    end else begin
      out_q <= out_d;
    end
  end

  assign hsync      = out_q.hsync;
  assign vsync      = out_q.vsync;
  assign videoOn    = out_q.video_on;
  assign pixelX     = out_q.pixel_x;
  assign pixelY     = out_q.pixel_y;
  assign frameStart = out_q.frame_start;

`ifdef VGA_FRAME_COUNT_EN
  // ---------------------------------------------------------------------------
  // Frame counter: steps on the same edge that raises frameStart.
  // ---------------------------------------------------------------------------
  frame_cnt_t frame_count_q;
  frame_cnt_t frame_count_d;

  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_wrap) begin
      frame_count_d = frame_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk25MHz) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frameCount = frame_count_q;
`endif

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_SYNC_START, default 656, first hsync-active horizontal count.
REQ-003 Parameter H_SYNC_END, default 752, first horizontal count after hsync.
REQ-004 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-005 Parameter V_SYNC_START, default 490, first vsync-active line.
REQ-006 Parameter V_SYNC_END, default 492, first line after vsync.
REQ-007 Parameter V_TOTAL, default 525, lines per frame.
REQ-008 clk25MHz  input  1  pixel clock; all logic on its rising edge.
REQ-009 reset_n  input  1  synchronous active-low reset.
REQ-010 enableVertCount  input  1  one-cycle line-wrap pulse from the upstream horizontal counter, coincident with horizontalCount==0.
REQ-011 horizontalCount  input  16  upstream horizontal position, 0..799.
REQ-012 verticalCount  output  16  current line number, 0..V_TOTAL-1.
REQ-013 hsync  output  1  horizontal sync, active low.
REQ-014 vsync  output  1  vertical sync, active low.
REQ-015 videoOn  output  1  high when the pixel is inside the visible area.
REQ-016 pixelX  output  10  visible column; 0 when videoOn is low.
REQ-017 pixelY  output  10  visible row; 0 when videoOn is low.
REQ-018 frameStart  output  1  one-cycle pulse on the first pixel of each frame.

Function
REQ-019 On a cycle with enableVertCount=1, verticalCount SHALL advance by 1, or wrap V_TOTAL-1 -> 0; otherwise it holds.
REQ-020 Every output SHALL be registered, with exactly one cycle of latency from the horizontalCount sample.
REQ-021 Decode SHALL use the effective line number: the post-advance value when enableVertCount=1, else the current verticalCount.
REQ-022 hsync SHALL be 0 iff H_SYNC_START <= horizontalCount < H_SYNC_END.
REQ-023 vsync SHALL be 0 iff V_SYNC_START <= effective line < V_SYNC_END.
REQ-024 videoOn SHALL be 1 iff horizontalCount < H_VISIBLE and effective line < V_VISIBLE.
REQ-025 pixelX and pixelY SHALL take the low 10 bits of horizontalCount and the effective line when videoOn is asserted.
REQ-026 frameStart SHALL pulse for one cycle when enableVertCount=1 and verticalCount==V_TOTAL-1 (the wrap to line 0).
REQ-027 horizontalCount >= 800 SHALL be treated as blanking: videoOn=0, hsync=1, and verticalCount unaffected.
REQ-028 enableVertCount held high for consecutive cycles SHALL advance verticalCount once per cycle, with no filtering.

Reset
REQ-029 While reset_n=0 at a clock edge, the block SHALL force verticalCount=0, hsync=1, vsync=1, videoOn=0, pixelX=0, pixelY=0, frameStart=0, and frameCount=0.
REQ-030 Reset asserted mid-frame SHALL take effect on the next edge, and enableVertCount SHALL be ignored during reset.
REQ-031 The first cycle after release SHALL decode line 0 with the sampled horizontalCount.

Configuration
REQ-032 With VGA_FRAME_COUNT_EN defined, the block SHALL add output frameCount (8 bits), which increments on each frameStart and wraps 255 -> 0.
REQ-033 Without VGA_FRAME_COUNT_EN, the block SHALL have no frameCount port and no frame-counter logic; all other behaviour is identical.

Structure
REQ-034 Package vga_timing_pkg SHALL hold all H/V timing constants (totals 800/525, visible, sync start/end) and their widths.
REQ-035 The vertical counter with its wrap logic SHALL be the sub-module vga_vert_counter; sync and visible-area decode SHALL live in vga_sync_gen.

Verification
REQ-036 Reset with horizontalCount=5 -> after the first post-reset edge: videoOn=1, pixelX=5, pixelY=0, hsync=1, vsync=1.
REQ-037 horizontalCount=656 on line 10 -> next cycle hsync=0, videoOn=0; horizontalCount=752 -> hsync=1.
REQ-038 enableVertCount pulse with verticalCount=489, horizontalCount=0 -> next cycle verticalCount=490, vsync=0; advancing to 492 -> vsync=1.
REQ-039 enableVertCount with verticalCount=524 -> next cycle verticalCount=0, frameStart=1 for one cycle, videoOn=1, pixelX=0, pixelY=0.
REQ-040 Full frame of 420000 cycles with VGA_FRAME_COUNT_EN -> frameCount advances by 1; after 256 frames it returns to its start value.
REQ-041 reset_n=0 for one cycle at line 300 -> verticalCount=0 and frameCount=0, and normal counting resumes after release.
